// File: rtl/sync_fifo_pkg.sv
// Shared sync_fifo defaults, depth/count-width derivation and the status-flag bundle.
// Imported by sync_fifo, fifo_ram, data_fifo successors and the bench.
package sync_fifo_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_ADDR_W     = 9;
  localparam int DEF_FWFT       = 0;
  localparam int DEF_AFULL_OFS  = 4;
  localparam int DEF_AEMPTY_OFS = 4;

  function automatic int fifo_depth(input int addr_w);
    return 1 << addr_w;
  endfunction

  // One extra bit so a completely full FIFO (count == DEPTH) is representable.
  function automatic int cnt_width(input int addr_w);
    return addr_w + 1;
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
  } fifo_flags_t;

endpackage

// File: rtl/fifo_ram.sv
// Simple dual-port storage, registered read-first port; 1-cycle read latency.
// No backpressure: the caller issues we/re only for accepted transfers.
module fifo_ram
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [fifo_depth(ADDR_W)];

  // Read-first: a full FIFO reading and writing the same slot gets the old word.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO on fifo_ram; dout 2 edges after re (FWFT=0) or head-on-dout (FWFT=1).
// Writes dropped when full, reads when empty; SYNC_FIFO_ERRFLAG_EN adds wr_err/rd_err pulses.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int FWFT       = DEF_FWFT,
  parameter int AFULL_OFS  = DEF_AFULL_OFS,
  parameter int AEMPTY_OFS = DEF_AEMPTY_OFS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] din,
  input  logic              we,
  input  logic              re,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [ADDR_W:0]   count,
  output logic              wr_err,
  output logic              rd_err
);

  localparam int CNT_W = cnt_width(ADDR_W);
  localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(fifo_depth(ADDR_W));
  localparam logic [CNT_W-1:0]  AFULL_TH  = CNT_W'(fifo_depth(ADDR_W) - AFULL_OFS);
  localparam logic [CNT_W-1:0]  AEMPTY_TH = CNT_W'(AEMPTY_OFS);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
  localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, empty: 1'b1,
                                        almost_full: 1'b0, almost_empty: 1'b1};

  logic [ADDR_W-1:0] wptr_q, rptr_q;
  logic [CNT_W-1:0]  cnt_q, cnt_nxt;
  fifo_flags_t       flags_q, flags_nxt;
  logic              wr_acc, rd_acc, ram_re, empty_nxt;
  logic [DATA_W-1:0] ram_rdata;

  assign wr_acc = we && (!flags_q.full || rd_acc);

  generate
    if (FWFT != 0) begin : g_fwft
      // The RAM output register is the head word; empty is "no head fetched yet".
      logic             head_vld;
      logic [CNT_W-1:0] unfetched;
      assign head_vld  = !flags_q.empty;
      assign unfetched = cnt_q - CNT_W'(head_vld);
      assign rd_acc    = re && head_vld;
      assign ram_re    = (unfetched != '0) && (!head_vld || rd_acc);
      assign empty_nxt = !(ram_re || (head_vld && !rd_acc));
      assign dout      = head_vld ? ram_rdata : '0;
    end else begin : g_std
      logic              rd_pend_q;
      logic [DATA_W-1:0] dout_q;
      assign rd_acc    = re && !flags_q.empty;
      assign ram_re    = rd_acc;
      assign empty_nxt = (cnt_nxt == '0);
      assign dout      = dout_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rd_pend_q <= 1'b0;
          dout_q    <= '0;
        end else begin
          rd_pend_q <= rd_acc;
          if (rd_pend_q) dout_q <= ram_rdata;
        end
      end
    end
  endgenerate

  always_comb begin
    cnt_nxt = cnt_q;
    if (wr_acc && !rd_acc)      cnt_nxt = cnt_q + CNT_ONE;
    else if (rd_acc && !wr_acc) cnt_nxt = cnt_q - CNT_ONE;
    flags_nxt.full         = (cnt_nxt == DEPTH_C);
    flags_nxt.empty        = empty_nxt;
    flags_nxt.almost_full  = (cnt_nxt >= AFULL_TH);
    flags_nxt.almost_empty = (cnt_nxt <= AEMPTY_TH);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      flags_q <= FLAGS_RST;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + PTR_ONE;
      if (ram_re) rptr_q <= rptr_q + PTR_ONE;
      cnt_q   <= cnt_nxt;
      flags_q <= flags_nxt;
    end
  end

  fifo_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wptr_q),
    .wdata (din),
    .re    (ram_re),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

`ifdef SYNC_FIFO_ERRFLAG_EN
  logic wr_err_q, rd_err_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= we && !wr_acc;
      rd_err_q <= re && !rd_acc;
    end
  end
  assign wr_err = wr_err_q;
  assign rd_err = rd_err_q;
`else
  assign wr_err = 1'b0;
  assign rd_err = 1'b0;
`endif

  assign full         = flags_q.full;
  assign empty        = flags_q.empty;
  assign almost_full  = flags_q.almost_full;
  assign almost_empty = flags_q.almost_empty;
  assign count        = cnt_q;

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench: DUT u0 standard read, DUT u1 first-word-fall-through; 16 deep, 32 bit.
module tb_sync_fifo;
  import sync_fifo_pkg::*;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int CW = cnt_width(AW);
`ifdef SYNC_FIFO_ERRFLAG_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [DW-1:0] din0 = '0, din1 = '0;
  logic we0 = 1'b0, re0 = 1'b0, we1 = 1'b0, re1 = 1'b0;
  logic [DW-1:0] dout0, dout1;
  logic full0, empty0, af0, ae0, wr_err0, rd_err0;
  logic full1, empty1, af1, ae1, wr_err1, rd_err1;
  logic [CW-1:0] count0, count1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(0), .AFULL_OFS(4), .AEMPTY_OFS(4)) u0 (
    .clk(clk), .rst(rst), .din(din0), .we(we0), .re(re0), .dout(dout0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(count0), .wr_err(wr_err0), .rd_err(rd_err0));

  sync_fifo #(.DATA_W(DW), .ADDR_W(AW), .FWFT(1), .AFULL_OFS(4), .AEMPTY_OFS(4)) u1 (
    .clk(clk), .rst(rst), .din(din1), .we(we1), .re(re1), .dout(dout1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(count1), .wr_err(wr_err1), .rd_err(rd_err1));

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    n_cmp++; if (count0 !== 0)   begin n_bad++; $display("FAIL rst_count: got %0d want 0", count0); end
    n_cmp++; if (empty0 !== 1'b1) begin n_bad++; $display("FAIL rst_empty: got %b want 1", empty0); end
    n_cmp++; if (ae0 !== 1'b1)    begin n_bad++; $display("FAIL rst_aempty: got %b want 1", ae0); end
    n_cmp++; if (full0 !== 1'b0)  begin n_bad++; $display("FAIL rst_full: got %b want 0", full0); end
    n_cmp++; if (af0 !== 1'b0)    begin n_bad++; $display("FAIL rst_afull: got %b want 0", af0); end
    n_cmp++; if (dout0 !== 0)     begin n_bad++; $display("FAIL rst_dout: got %h want 0", dout0); end
    n_cmp++; if (wr_err0 !== 1'b0 || rd_err0 !== 1'b0)
      begin n_bad++; $display("FAIL rst_err: got %b%b want 00", wr_err0, rd_err0); end
    n_cmp++; if (empty1 !== 1'b1 || dout1 !== 0)
      begin n_bad++; $display("FAIL rst_fwft: got empty=%b dout=%h want 1/0", empty1, dout1); end
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 16; k++) begin
      din0 = DW'(k); we0 = 1'b1;
      cyc();
      n_cmp++; if (count0 !== CW'(k)) begin n_bad++; $display("FAIL fill_count[%0d]: got %0d want %0d", k, count0, k); end
      n_cmp++; if (af0 !== (k >= 12)) begin n_bad++; $display("FAIL fill_afull[%0d]: got %b want %b", k, af0, (k >= 12)); end
      n_cmp++; if (ae0 !== (k <= 4))  begin n_bad++; $display("FAIL fill_aempty[%0d]: got %b want %b", k, ae0, (k <= 4)); end
      n_cmp++; if (full0 !== (k == 16)) begin n_bad++; $display("FAIL fill_full[%0d]: got %b want %b", k, full0, (k == 16)); end
    end
    we0 = 1'b0;
  endtask

  task automatic test_overflow();
    din0 = 32'hDEAD; we0 = 1'b1; re0 = 1'b0;
    cyc();
    we0 = 1'b0;
    n_cmp++; if (count0 !== 16) begin n_bad++; $display("FAIL ovf_count: got %0d want 16", count0); end
    n_cmp++; if (wr_err0 !== ERR_EN) begin n_bad++; $display("FAIL ovf_wr_err: got %b want %b", wr_err0, ERR_EN); end
    cyc();
    n_cmp++; if (wr_err0 !== 1'b0) begin n_bad++; $display("FAIL ovf_wr_err_clear: got %b want 0", wr_err0); end
    for (int i = 1; i <= 16; i++) begin
      re0 = 1'b1;
      cyc();
      if (i >= 2) begin
        n_cmp++; if (dout0 !== DW'(i - 1)) begin n_bad++; $display("FAIL ovf_drain[%0d]: got %h want %h", i, dout0, i - 1); end
      end
    end
    re0 = 1'b0;
    cyc();
    n_cmp++; if (dout0 !== 16) begin n_bad++; $display("FAIL ovf_last: got %h want 10", dout0); end
    n_cmp++; if (empty0 !== 1'b1 || count0 !== 0)
      begin n_bad++; $display("FAIL ovf_empty: got empty=%b count=%0d want 1/0", empty0, count0); end
  endtask

  task automatic test_read_std();
    we0 = 1'b1; din0 = 32'hA; cyc();
    din0 = 32'hB; cyc();
    din0 = 32'hC; cyc();
    we0 = 1'b0; re0 = 1'b1;
    cyc();
    cyc();
    n_cmp++; if (dout0 !== 32'hA) begin n_bad++; $display("FAIL rd_a: got %h want a", dout0); end
    cyc();
    n_cmp++; if (dout0 !== 32'hB) begin n_bad++; $display("FAIL rd_b: got %h want b", dout0); end
    n_cmp++; if (empty0 !== 1'b1) begin n_bad++; $display("FAIL rd_empty: got %b want 1", empty0); end
    cyc();
    n_cmp++; if (dout0 !== 32'hC) begin n_bad++; $display("FAIL rd_c: got %h want c", dout0); end
    n_cmp++; if (rd_err0 !== ERR_EN) begin n_bad++; $display("FAIL rd_err: got %b want %b", rd_err0, ERR_EN); end
    re0 = 1'b0;
    cyc();
    n_cmp++; if (dout0 !== 32'hC) begin n_bad++; $display("FAIL rd_hold: got %h want c", dout0); end
    n_cmp++; if (rd_err0 !== 1'b0) begin n_bad++; $display("FAIL rd_err_clear: got %b want 0", rd_err0); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin
      din0 = DW'(32'h100 + i); we0 = 1'b1; cyc();
    end
    for (int k = 1; k <= 40; k++) begin
      din0 = DW'(32'h110 + k - 1); we0 = 1'b1; re0 = 1'b1;
      cyc();
      n_cmp++; if (count0 !== 16 || full0 !== 1'b1)
        begin n_bad++; $display("FAIL b2b_count[%0d]: got %0d full=%b want 16/1", k, count0, full0); end
      if (k >= 2) begin
        n_cmp++; if (dout0 !== DW'(32'h100 + k - 2))
          begin n_bad++; $display("FAIL b2b_order[%0d]: got %h want %h", k, dout0, 32'h100 + k - 2); end
      end
    end
    we0 = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      re0 = 1'b1;
      cyc();
      n_cmp++; if (dout0 !== DW'(32'h100 + 38 + i))
        begin n_bad++; $display("FAIL b2b_drain[%0d]: got %h want %h", i, dout0, 32'h100 + 38 + i); end
    end
    re0 = 1'b0;
    cyc();
    n_cmp++; if (dout0 !== 32'h137 || empty0 !== 1'b1)
      begin n_bad++; $display("FAIL b2b_tail: got %h empty=%b want 137/1", dout0, empty0); end
  endtask

  task automatic test_fwft();
    din1 = 32'h55; we1 = 1'b1;
    cyc();
    we1 = 1'b0;
    n_cmp++; if (count1 !== 1) begin n_bad++; $display("FAIL fwft_count: got %0d want 1", count1); end
    cyc();
    n_cmp++; if (dout1 !== 32'h55 || empty1 !== 1'b0)
      begin n_bad++; $display("FAIL fwft_head: got %h empty=%b want 55/0", dout1, empty1); end
    re1 = 1'b1;
    cyc();
    re1 = 1'b0;
    n_cmp++; if (empty1 !== 1'b1 || count1 !== 0)
      begin n_bad++; $display("FAIL fwft_pop: got empty=%b count=%0d want 1/0", empty1, count1); end
    for (int i = 1; i <= 3; i++) begin
      din1 = DW'(32'h60 + i); we1 = 1'b1; cyc();
    end
    we1 = 1'b0;
    cyc();
    n_cmp++; if (dout1 !== 32'h61) begin n_bad++; $display("FAIL fwft_first: got %h want 61", dout1); end
    re1 = 1'b1;
    for (int i = 2; i <= 3; i++) begin
      cyc();
      n_cmp++; if (dout1 !== DW'(32'h60 + i) || empty1 !== 1'b0)
        begin n_bad++; $display("FAIL fwft_stream[%0d]: got %h empty=%b want %h/0", i, dout1, empty1, 32'h60 + i); end
    end
    cyc();
    n_cmp++; if (empty1 !== 1'b1) begin n_bad++; $display("FAIL fwft_drained: got %b want 1", empty1); end
    cyc();
    re1 = 1'b0;
    n_cmp++; if (rd_err1 !== ERR_EN) begin n_bad++; $display("FAIL fwft_rd_err: got %b want %b", rd_err1, ERR_EN); end
  endtask

  task automatic test_reset_mid();
    for (int k = 1; k <= 7; k++) begin
      din0 = DW'(32'h200 + k); we0 = 1'b1; cyc();
    end
    n_cmp++; if (count0 !== 7) begin n_bad++; $display("FAIL mid_count: got %0d want 7", count0); end
    din0 = 32'h208;
    #1 rst = 1'b0;
    #1;
    n_cmp++; if (empty0 !== 1'b1 || count0 !== 0 || dout0 !== 0)
      begin n_bad++; $display("FAIL mid_clear: got empty=%b count=%0d dout=%h want 1/0/0", empty0, count0, dout0); end
    we0 = 1'b0;
    #1 rst = 1'b1;
    din0 = 32'h300; we0 = 1'b1;
    cyc();
    we0 = 1'b0;
    n_cmp++; if (count0 !== 1) begin n_bad++; $display("FAIL mid_first_wr: got %0d want 1", count0); end
    re0 = 1'b1;
    cyc();
    re0 = 1'b0;
    cyc();
    n_cmp++; if (dout0 !== 32'h300) begin n_bad++; $display("FAIL mid_first_rd: got %h want 300", dout0); end
  endtask

  initial begin
    #1;
    test_reset();
    test_fill();
    test_overflow();
    test_read_std();
    test_back_to_back();
    test_fwft();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 SHALL have parameter DATA_W, default 32, data word width in bits (1..72).
REQ-002 SHALL have parameter ADDR_W, default 9, log2 of depth; DEPTH = 2**ADDR_W (4..4096 words).
REQ-003 SHALL have parameter FWFT, default 0: 0 = standard read, 1 = first-word-fall-through.
REQ-004 SHALL have parameter AFULL_OFS, default 4, almost-full threshold offset from DEPTH.
REQ-005 SHALL have parameter AEMPTY_OFS, default 4, almost-empty threshold.
REQ-006 SHALL have ports:
  clk  in  1  single clock, all logic on rising edge.
  rst  in  1  asynchronous, active-low reset.
  din  in  DATA_W  write data.
  we  in  1  write enable.
  re  in  1  read enable (FWFT=1: acknowledge of the word on dout).
  dout  out  DATA_W  read data.
  full, empty, almost_full, almost_empty  out  1  registered status flags.
  count  out  ADDR_W+1  words stored.
  wr_err, rd_err  out  1  overflow/underflow pulses.

Function
REQ-007 SHALL accept a write when we=1 and full=0; din is stored at the write pointer, which increments modulo DEPTH.
REQ-008 SHALL accept a read when re=1 and empty=0; the read pointer increments modulo DEPTH.
REQ-009 SHALL ignore a write while full=1, except when a read is accepted in the same cycle; then both occur and count is unchanged.
REQ-010 SHALL ignore a read while empty=1 regardless of we (no write-to-read bypass).
REQ-011 SHALL update count each cycle: +1 on write only, -1 on read only, unchanged on both or neither; count SHALL never exceed DEPTH or underflow.
REQ-012 SHALL drive full=(count==DEPTH), empty=(count==0) from registers valid in the cycle after the causing edge.
REQ-013 SHALL drive almost_full=(count>=DEPTH-AFULL_OFS), almost_empty=(count<=AEMPTY_OFS).
REQ-014 FWFT=0: a read accepted at edge N SHALL present the word on dout after edge N+1 (BRAM latency 1); dout SHALL hold its value otherwise.
REQ-015 FWFT=1: the head word SHALL be on dout whenever empty=0; a write into an empty FIFO at edge N SHALL make empty=0 and dout valid after edge N+1 (prefetch through the same RAM port); re SHALL advance dout to the next word with no bubble when count>=2.
REQ-016 SHALL order words strictly first-in first-out across pointer wrap-around.

Reset
REQ-017 rst=0 SHALL immediately clear pointers, count, dout, wr_err, rd_err, full, almost_full to 0 and set empty and almost_empty to 1.
REQ-018 Reset asserted mid-operation SHALL discard all stored words; RAM contents need not be cleared.
REQ-019 SHALL accept writes from the first rising edge after rst deasserts.

Configuration
REQ-020 With macro SYNC_FIFO_ERRFLAG_EN defined, wr_err SHALL pulse high one cycle after a rejected write (REQ-009), and rd_err SHALL pulse high one cycle after a rejected read (REQ-010).
REQ-021 Without SYNC_FIFO_ERRFLAG_EN, wr_err and rd_err SHALL be tied to 0 and no error logic SHALL be synthesised.

Structure
REQ-022 Default parameter values and the DEPTH/count-width derivation SHALL live in shared package sync_fifo_pkg, reused by data_fifo successors and by the bench.
REQ-023 Storage SHALL be a sub-module fifo_ram: simple dual-port, one write port, one registered synchronous read port, inferable as block RAM; pointer/flag/FWFT logic stays in sync_fifo.

Verification (ADDR_W=4, DEPTH=16, DATA_W=32, offsets 4)
REQ-024 Reset, then write 0x1..0x10 on 16 consecutive cycles -> full=1 after the 16th edge, count=16, almost_full=1 from count=12.
REQ-025 Write when full with re=0 (din=0xDEAD) -> count stays 16, word discarded, wr_err pulses 1 cycle (macro defined), or stays 0 (macro undefined).
REQ-026 FWFT=0: fill 3 words 0xA,0xB,0xC, assert re for 3 cycles -> dout 0xA,0xB,0xC on the cycles after each read, empty=1 after the 3rd; a 4th re -> rd_err pulse, dout holds 0xC.
REQ-027 FWFT=1: write 0x55 into an empty FIFO -> dout=0x55 and empty=0 one cycle later with no re; re -> empty=1 next cycle.
REQ-028 Full FIFO, we=re=1 for 40 cycles with an incrementing din -> count stays 16, output order contiguous across two pointer wraps.
REQ-029 Assert rst at count=7 mid-burst -> empty=1, count=0, dout=0 immediately; the next written word is the first one read.
